// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: servo PWM frame generator driven by a clock-enable tick.
// Produces a high pulse of active_width ticks at the start of every
// FRAME_TICKS-tick frame. Width commands are taken over a valid/ready
// handshake into a shadow register and only applied at frame boundaries,
// so a pulse is never glitched or truncated.
// Optional feature macro: SERVO_PWM_CLAMP_EN saturates accepted widths to
// [MIN_TICKS, MAX_TICKS] before they are stored in the shadow register.
`timescale 1ns/1ps

module servo_pwm_gen #(
  parameter int FRAME_TICKS   = 20000,
  parameter int MIN_TICKS     = 1000,
  parameter int MAX_TICKS     = 2000,
  parameter int DEFAULT_TICKS = 1500,
  parameter int CW            = 16
) (
  input  logic          in_clk,
  input  logic          reset_n,
  input  logic          tick_en,
  input  logic          run,
  input  logic [CW-1:0] cmd_width,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic          pwm_out,
  output logic          frame_start,
  output logic [CW-1:0] active_width
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

`ifdef SERVO_PWM_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  localparam logic [CW-1:0] FRAME_LAST  = CW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0] MIN_W       = CW'(MIN_TICKS);
  localparam logic [CW-1:0] MAX_W       = CW'(MAX_TICKS);
  localparam logic [CW-1:0] DEFAULT_W   = CW'(DEFAULT_TICKS);

  state_t        state, state_next;
  logic [CW-1:0] frame_cnt, cnt_next;
  logic [CW-1:0] shadow, shadow_next;
  logic [CW-1:0] active_next;
  logic          pending, pending_next;
  logic          accept;
  logic          boundary;
  logic          pwm_next;
  logic [CW-1:0] cmd_stored;

  assign cmd_ready = ~pending;

  // Width as it will be written to the shadow (saturated when clamping is built in)
  always_comb begin
    cmd_stored = cmd_width;
    if (CLAMP) begin
      if (cmd_width < MIN_W) begin
        cmd_stored = MIN_W;
      end else if (cmd_width > MAX_W) begin
        cmd_stored = MAX_W;
      end
    end
  end

  // Next-state logic: frame boundaries, counter advance, shadow/pending handshake
  always_comb begin
    state_next   = state;
    cnt_next     = frame_cnt;
    active_next  = active_width;
    pending_next = pending;
    shadow_next  = shadow;

    accept   = cmd_valid && !pending;
    boundary = tick_en && (((state == IDLE) && run) ||
                           ((state == RUN) && (frame_cnt == FRAME_LAST)));

    if (boundary) begin
      if (pending) begin
        active_next  = shadow;
        pending_next = 1'b0;
      end
      cnt_next   = '0;
      state_next = run ? RUN : IDLE;
    end else if (tick_en && (state == RUN)) begin
      cnt_next = frame_cnt + 1'b1;
    end

    // A command taken on a boundary lands in the shadow only; no bypass
    if (accept) begin
      shadow_next  = cmd_stored;
      pending_next = 1'b1;
    end

    pwm_next = (state_next == RUN) && (cnt_next < active_next);
  end

  // State, counter, width registers and registered outputs
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      pending      <= 1'b0;
      shadow       <= DEFAULT_W;
      active_width <= DEFAULT_W;
      pwm_out      <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      state        <= state_next;
      frame_cnt    <= cnt_next;
      pending      <= pending_next;
      shadow       <= shadow_next;
      active_width <= active_next;
      frame_start  <= boundary && run;
      if (tick_en) begin
        pwm_out <= pwm_next;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed bench for servo_pwm_gen with a short frame
// (40 ticks) so several frames fit in a small simulation. A monitor records
// high time and period (in clocks) of every completed frame.
`timescale 1ns/1ps

module tb_servo_pwm_gen;

  localparam int FRAME = 40;
  localparam int DIV   = 4;
  localparam int DEF_W = 15;
`ifdef SERVO_PWM_CLAMP_EN
  localparam int W_ZERO = 10;
  localparam int W_BIG  = 20;
`else
  localparam int W_ZERO = 0;
  localparam int W_BIG  = 25000;
`endif
  localparam int BIG_TICKS = (W_BIG < FRAME) ? W_BIG : FRAME;

  logic        in_clk = 1'b0;
  logic        reset_n;
  logic        tick_en;
  logic        run;
  logic [15:0] cmd_width;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        pwm_out;
  logic        frame_start;
  logic [15:0] active_width;

  int passed = 0;
  int total  = 0;
  int tick_div = DIV;
  int fs_count = 0;
  int fs_before;
  int frame_hi[$];
  int frame_per[$];

  servo_pwm_gen #(
    .FRAME_TICKS  (FRAME),
    .MIN_TICKS    (10),
    .MAX_TICKS    (20),
    .DEFAULT_TICKS(DEF_W),
    .CW           (16)
  ) dut (
    .in_clk      (in_clk),
    .reset_n     (reset_n),
    .tick_en     (tick_en),
    .run         (run),
    .cmd_width   (cmd_width),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .active_width(active_width)
  );

  always #5 in_clk = ~in_clk;

  // Tick source: one-cycle tick every tick_div clocks, driven on the falling edge
  initial begin : tick_gen
    int tcnt;
    tcnt = 0;
    tick_en = 1'b0;
    forever begin
      @(negedge in_clk);
      tcnt++;
      tick_en = ((tcnt % tick_div) == 0);
    end
  end

  // Frame monitor: counts clocks and pwm-high clocks between frame_start pulses
  initial begin : monitor
    int  hi;
    int  per;
    bit  in_frame;
    hi = 0;
    per = 0;
    in_frame = 1'b0;
    forever begin
      @(negedge in_clk);
      if (!reset_n) begin
        in_frame = 1'b0;
      end else begin
        if (frame_start) begin
          fs_count++;
          if (in_frame) begin
            frame_hi.push_back(hi);
            frame_per.push_back(per);
          end
          hi = 0;
          per = 0;
          in_frame = 1'b1;
        end
        if (in_frame) begin
          per++;
          if (pwm_out) hi++;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got == exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one command for a single clock while cmd_ready is high
  task automatic applyStimulus(input int w);
    @(negedge in_clk);
    cmd_valid = 1'b1;
    cmd_width = 16'(w);
    @(negedge in_clk);
    cmd_valid = 1'b0;
  endtask

  // Advance to the next sampled frame_start; a missing pulse counts as a failure
  task automatic waitFrameStart(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge in_clk);
      #1;
      n++;
    end while (!frame_start && n < 2000);
    if (!frame_start) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  initial begin : main
    int offset;
    reset_n   = 1'b0;
    run       = 1'b0;
    cmd_valid = 1'b0;
    cmd_width = '0;
    repeat (3) @(negedge in_clk);
    checkOutput("rst_pwm", int'(pwm_out), 0);
    checkOutput("rst_fs", int'(frame_start), 0);
    checkOutput("rst_ready", int'(cmd_ready), 1);
    checkOutput("rst_aw", int'(active_width), DEF_W);
    reset_n = 1'b1;
    repeat (5) @(negedge in_clk);
    checkOutput("idle_pwm", int'(pwm_out), 0);
    run = 1'b1;

    // Frame 1: default width; command 12 accepted mid-pulse, then 18 back-pressured
    waitFrameStart("f1");
    checkOutput("f1_aw", int'(active_width), DEF_W);
    checkOutput("f1_pwm_rise", int'(pwm_out), 1);
    repeat (8) @(posedge in_clk);
    applyStimulus(12);
    checkOutput("f1_ready_drop", int'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_width = 16'd18;
    repeat (20) @(negedge in_clk);
    checkOutput("f1_ready_held", int'(cmd_ready), 0);
    cmd_valid = 1'b0;

    // Frame 2: 12 applied; then 11 presented exactly on the next boundary cycle
    waitFrameStart("f2");
    checkOutput("f2_ready_back", int'(cmd_ready), 1);
    checkOutput("f2_aw", int'(active_width), 12);
    repeat (FRAME * DIV - 1) @(posedge in_clk);
    @(negedge in_clk);
    cmd_valid = 1'b1;
    cmd_width = 16'd11;
    @(posedge in_clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("f3_same_cycle_fs", int'(frame_start), 1);
    checkOutput("f3_same_cycle_ready", int'(cmd_ready), 0);
    checkOutput("f3_no_bypass_aw", int'(active_width), 12);

    waitFrameStart("f4");
    checkOutput("f4_aw", int'(active_width), 11);
    @(negedge in_clk);
    checkOutput("f1_hi", frame_hi[0], DEF_W * DIV);
    checkOutput("f1_per", frame_per[0], FRAME * DIV);
    checkOutput("f2_hi", frame_hi[1], 12 * DIV);
    checkOutput("f3_hi", frame_hi[2], 12 * DIV);

    // Width 0 then an over-long width
    repeat (10) @(posedge in_clk);
    applyStimulus(0);
    waitFrameStart("f5");
    checkOutput("f5_aw", int'(active_width), W_ZERO);
    checkOutput("f5_pwm", int'(pwm_out), (W_ZERO > 0) ? 1 : 0);
    repeat (10) @(posedge in_clk);
    applyStimulus(25000);
    waitFrameStart("f6");
    checkOutput("f6_aw", int'(active_width), W_BIG);
    @(negedge in_clk);
    checkOutput("f4_hi", frame_hi[3], 11 * DIV);
    checkOutput("f5_hi", frame_hi[4], W_ZERO * DIV);
    checkOutput("f5_per", frame_per[4], FRAME * DIV);

    // Frame 7: drop run right after the frame starts; frame must complete
    waitFrameStart("f7");
    run = 1'b0;
    offset = BIG_TICKS * DIV - 1;
    repeat (offset) @(posedge in_clk);
    #1;
    checkOutput("stop_pulse_kept", int'(pwm_out), 1);
    repeat (FRAME * DIV - offset) @(posedge in_clk);
    #1;
    checkOutput("stop_pwm_low", int'(pwm_out), 0);
    checkOutput("stop_no_fs", int'(frame_start), 0);
    fs_before = fs_count;
    repeat (200) @(negedge in_clk);
    checkOutput("idle_no_frames", fs_count, fs_before);
    checkOutput("idle_pwm_low", int'(pwm_out), 0);
    checkOutput("f6_hi", frame_hi[5], BIG_TICKS * DIV);

    // Restart, then asynchronous reset in the middle of the pulse
    @(negedge in_clk);
    run = 1'b1;
    waitFrameStart("restart");
    repeat (5) @(posedge in_clk);
    #1;
    checkOutput("pre_reset_pwm", int'(pwm_out), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_pwm", int'(pwm_out), 0);
    checkOutput("async_rst_aw", int'(active_width), DEF_W);
    tick_div = 1;
    repeat (3) @(negedge in_clk);
    reset_n = 1'b1;
    @(negedge in_clk);
    checkOutput("post_rst_ready", int'(cmd_ready), 1);

    // Tick on every clock: no missed counts
    waitFrameStart("div1_a");
    checkOutput("div1_aw", int'(active_width), DEF_W);
    waitFrameStart("div1_b");
    @(negedge in_clk);
    checkOutput("div1_hi", frame_hi[$], DEF_W);
    checkOutput("div1_per", frame_per[$], FRAME);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Servo pulse generator that sits directly downstream of the servo controller's clock-enable divider. It consumes the divider's single-cycle tick, typically 1 µs, and produces a standard servo PWM frame: a high pulse of commanded width at the start of every fixed-length frame. Width commands arrive over a valid/ready handshake. They are double-buffered and take effect only at frame boundaries, so the output never emits a glitched or truncated pulse.

## Interface
Parameters:
- FRAME_TICKS, 20000: frame period in ticks (20 ms at a 1 µs tick).
- MIN_TICKS, 1000: minimum legal pulse width in ticks.
- MAX_TICKS, 2000: maximum legal pulse width in ticks.
- DEFAULT_TICKS, 1500: pulse width after reset (servo centre).
- CW, 16: width of the counter and command; must satisfy 2^CW > FRAME_TICKS.

Ports:
- in_clk, input, 1: system clock; all logic is on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- tick_en, input, 1: one-in_clk-wide tick from the clock-enable divider.
- run, input, 1: enables frame generation; sampled only at frame boundaries.
- cmd_width, input, CW: requested pulse width in ticks.
- cmd_valid, input, 1: cmd_width is valid.
- cmd_ready, output, 1: block can accept a command (equals ~pending).
- pwm_out, output, 1: registered servo PWM output.
- frame_start, output, 1: one-cycle pulse, registered, asserted in the same cycle pwm_out begins a frame.
- active_width, output, CW: width currently being generated.

## Operation
- States:
  - IDLE: pwm_out=0, counter held at 0.
  - RUN: counter advances on tick_en.
- Shadow register plus pending flag:
  - A command is accepted when cmd_valid && cmd_ready. On acceptance, shadow <= cmd_width and pending <= 1.
  - While pending=1, cmd_ready=0 and further commands are back-pressured.
- Frame boundary is a tick_en cycle that is either:
  - (a) in IDLE with run=1, or
  - (b) in RUN with frame_cnt == FRAME_TICKS-1.
- At a frame boundary:
  - If pending, active_width <= shadow and pending <= 0.
  - frame_cnt <= 0.
  - If run=1, enter or stay in RUN and pulse frame_start. If run=0 in case (b), go to IDLE.
- In RUN, on each tick_en that is not a boundary: frame_cnt <= frame_cnt+1.
- pwm_out <= RUN_next && (frame_cnt_next < active_width_next). It is registered and changes only on tick_en cycles or on reset.
- Width 0: pwm_out stays low for the whole frame, and frame_start still pulses.
- Width >= FRAME_TICKS: pwm_out stays high for the whole frame.
- Acceptance and boundary in the same cycle: the new command lands in the shadow and applies at the next boundary. There is no bypass.
- Deasserting run mid-frame has no effect until the current frame completes. The frame is never truncated.
- Reset (asynchronous, any time, including mid-pulse):
  - State IDLE, frame_cnt=0, pending=0, shadow=DEFAULT_TICKS, active_width=DEFAULT_TICKS.
  - pwm_out=0, frame_start=0, cmd_ready=1 after release.
- Counter arithmetic is unsigned CW bits and never wraps, because it is bounded by FRAME_TICKS-1.

## Timing
- pwm_out rises one in_clk after the tick_en cycle that starts a frame, in the same cycle as frame_start.
- The pulse lasts exactly active_width ticks (width × tick period), measured rise to fall on tick edges.
- The frame period is exactly FRAME_TICKS ticks when run stays high.
- Command latency:
  - Accepted to applied: at most one frame plus one in_clk.
  - cmd_ready returns to 1 one in_clk after the boundary that consumes the shadow.
- tick_en asserted on consecutive in_clk cycles (divisor 1) must be handled without missed counts.

## Configuration
- SERVO_PWM_CLAMP_EN
  - Defined: cmd_width is saturated at acceptance to [MIN_TICKS, MAX_TICKS] before it is stored in the shadow.
  - Undefined: cmd_width is stored unmodified, so widths 0 and >= FRAME_TICKS behave as described in Operation.

## Test plan
- Default frame: reset, then run=1 with a tick every 50 clocks. Expect pwm_out high for 1500 ticks, low for 18500 ticks, frame_start once every 20000 ticks, active_width=1500.
- Update at boundary: send cmd_width=1200 mid-frame. Expect cmd_ready to drop, the current pulse to remain 1500, the next frame's pulse to be 1200, and cmd_ready=1 one clock after that boundary.
- Back-pressure and same-cycle accept: hold cmd_valid with 1800 then 1100 while pending. Expect 1100 not accepted until ready; a 1100 accepted exactly on a boundary cycle applies one frame later.
- Clamp: with SERVO_PWM_CLAMP_EN, send 500 and then 3000. Expect 1000 and 2000. Without the macro, send 0 and 25000. Expect a frame fully low, then a frame fully high.
- Stop and reset: drop run mid-pulse. Expect the frame to complete and then pwm_out=0 in IDLE. Assert reset_n=0 mid-pulse. Expect pwm_out=0 immediately, active_width=1500, cmd_ready=1 after release.
